switch_4_port: RTL and testbench

- Four-port packet switch: each ingress port accepts one single-beat packet per cycle (source tag, one-hot/multi-hot target mask, data byte).
- Each packet is delivered to every egress port whose bit is set in the target mask (unicast, multicast, broadcast, loopback).
- Per-ingress FIFOs absorb contention; a per-egress round-robin arbiter selects among ingress heads.
- Sits between port-level MAC-style agents; no backpressure toward senders.

---
 rtl/switch_4_port.sv | 244 ++++++++++++++++++++++++
 tb/tb_switch_4_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_4_port.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// switch_4_port
//
// Four-port single-beat packet switch. Every ingress port has its own FIFO;
// the packet at each FIFO head is delivered once to every egress named in
// its target mask. Each egress picks among the ingress heads with a
// round-robin arbiter and registers the winner onto its output.
// No backpressure is given to senders: a packet that arrives at a full FIFO
// is dropped, and a packet with an all-zero target is discarded.
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   valid_in     [P]      packet present on ingress p
//   source_in    [P*P]    slice p = source tag (carried, not interpreted)
//   target_in    [P*P]    slice p = destination mask, bit k = egress k
//   data_in      [P*D]    slice p = payload
//   valid_out    [P]      one-cycle pulse per delivered packet on egress k
//   source_out   [P*P]    slice k = source tag of delivered packet
//   target_out   [P*P]    slice k = original full target mask
//   data_out     [P*D]    slice k = payload
//   drop_cnt     [P*8]    only with SWITCH_DROP_CNT_EN defined: slice p counts
//                         full-FIFO drops on ingress p, saturating at 255
//
// Optional feature macro: SWITCH_DROP_CNT_EN
// ---------------------------------------------------------------------------
module switch_4_port #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            valid_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  source_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0]  target_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PORTS-1:0]            valid_out,
    output logic [NUM_PORTS*NUM_PORTS-1:0]  source_out,
    output logic [NUM_PORTS*NUM_PORTS-1:0]  target_out,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out
`ifdef SWITCH_DROP_CNT_EN
    ,
    output logic [NUM_PORTS*8-1:0]          drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [NUM_PORTS-1:0]  mask_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // Per-ingress FIFO storage
    mask_t         src_mem [NUM_PORTS][FIFO_DEPTH];
    mask_t         tgt_mem [NUM_PORTS][FIFO_DEPTH];
    data_t         dat_mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0] rd_ptr     [NUM_PORTS];
    logic [AW-1:0] rd_ptr_nxt [NUM_PORTS];
    logic [AW-1:0] wr_ptr     [NUM_PORTS];
    logic [CW-1:0] count      [NUM_PORTS];

    // Egresses still owed the current head packet
    mask_t         pending [NUM_PORTS];

    // Round-robin pointer per egress
    logic [PW-1:0] rr_ptr  [NUM_PORTS];

    // Unpacked ingress slices and FIFO heads
    mask_t         in_src   [NUM_PORTS];
    mask_t         in_tgt   [NUM_PORTS];
    data_t         in_dat   [NUM_PORTS];
    mask_t         head_src [NUM_PORTS];
    mask_t         head_tgt [NUM_PORTS];
    data_t         head_dat [NUM_PORTS];

    logic [NUM_PORTS-1:0] not_empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    // Arbitration results
    logic [NUM_PORTS-1:0] gnt_vld;
    logic [PW-1:0]        gnt_idx [NUM_PORTS];
    mask_t                served  [NUM_PORTS];
    mask_t                remain  [NUM_PORTS];

    // -----------------------------------------------------------------------
    // Ingress decode. Fullness is taken from the registered count, so a
    // same-cycle pop never makes room for the arriving packet.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            in_src[p]     = source_in[p*NUM_PORTS +: NUM_PORTS];
            in_tgt[p]     = target_in[p*NUM_PORTS +: NUM_PORTS];
            in_dat[p]     = data_in[p*DATA_WIDTH +: DATA_WIDTH];
            not_empty[p]  = (count[p] != '0);
            full[p]       = (count[p] == CW'(FIFO_DEPTH));
            accept[p]     = valid_in[p] && (in_tgt[p] != '0);
            push[p]       = accept[p] && !full[p];
            head_src[p]   = src_mem[p][rd_ptr[p]];
            head_tgt[p]   = tgt_mem[p][rd_ptr[p]];
            head_dat[p]   = dat_mem[p][rd_ptr[p]];
            rd_ptr_nxt[p] = rd_ptr[p] + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Per-egress round-robin arbitration over ingress heads that still owe
    // this egress a copy, then fold grants back per ingress.
    // -----------------------------------------------------------------------
    always_comb begin
        int idx;
        idx = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            gnt_vld[k] = 1'b0;
            gnt_idx[k] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = (int'(rr_ptr[k]) + i) % NUM_PORTS;
                if (!gnt_vld[k] && not_empty[idx] && pending[idx][k]) begin
                    gnt_vld[k] = 1'b1;
                    gnt_idx[k] = PW'(idx);
                end
            end
        end

        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            served[p] = '0;
        end
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (gnt_vld[k]) begin
                served[gnt_idx[k]][k] = 1'b1;
            end
        end

        // The head leaves once the last owed egress is served this cycle.
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            remain[p] = pending[p] & ~served[p];
            pop[p]    = (served[p] != '0) && (remain[p] == '0);
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by count)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) begin
                src_mem[p][wr_ptr[p]] <= in_src[p];
                tgt_mem[p][wr_ptr[p]] <= in_tgt[p];
                dat_mem[p][wr_ptr[p]] <= in_dat[p];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, occupancy and head pending mask
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rd_ptr[p]  <= '0;
                wr_ptr[p]  <= '0;
                count[p]   <= '0;
                pending[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr_nxt[p];
                end
                count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);

                // Whichever entry is head after this edge starts with its full
                // target as the pending mask: the next stored entry, or the
                // arriving one when the FIFO drains to it.
                if (pop[p]) begin
                    if (count[p] > CW'(1)) begin
                        pending[p] <= tgt_mem[p][rd_ptr_nxt[p]];
                    end else if (push[p]) begin
                        pending[p] <= in_tgt[p];
                    end else begin
                        pending[p] <= '0;
                    end
                end else if (!not_empty[p]) begin
                    if (push[p]) begin
                        pending[p] <= in_tgt[p];
                    end
                end else begin
                    pending[p] <= remain[p];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Egress registers and round-robin pointer update. Without a grant the
    // payload fields hold their previous values.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= '0;
            source_out <= '0;
            target_out <= '0;
            data_out   <= '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                rr_ptr[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                valid_out[k] <= gnt_vld[k];
                if (gnt_vld[k]) begin
                    source_out[k*NUM_PORTS +: NUM_PORTS]  <= head_src[gnt_idx[k]];
                    target_out[k*NUM_PORTS +: NUM_PORTS]  <= head_tgt[gnt_idx[k]];
                    data_out[k*DATA_WIDTH +: DATA_WIDTH] <= head_dat[gnt_idx[k]];
                    rr_ptr[k] <= PW'((int'(gnt_idx[k]) + 1) % NUM_PORTS);
                end
            end
        end
    end

`ifdef SWITCH_DROP_CNT_EN
    // -----------------------------------------------------------------------
    // Full-FIFO drop counters (zero-target discards are not counted)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (accept[p] && full[p] && (drop_cnt[p*8 +: 8] != 8'hFF)) begin
                    drop_cnt[p*8 +: 8] <= drop_cnt[p*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_4_port.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_switch_4_port
//
// Directed scoreboard bench for switch_4_port. Stimulus pushes hand-computed
// expected packets into per (ingress, egress) queues; a monitor on the
// falling edge pops and compares whenever an egress pulses valid_out.
// Expected delivery cycles are given where arbitration makes them fixed.
// ---------------------------------------------------------------------------
module tb_switch_4_port;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int FD = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NP-1:0]       valid_in;
    logic [NP*NP-1:0]    source_in;
    logic [NP*NP-1:0]    target_in;
    logic [NP*DW-1:0]    data_in;
    logic [NP-1:0]       valid_out;
    logic [NP*NP-1:0]    source_out;
    logic [NP*NP-1:0]    target_out;
    logic [NP*DW-1:0]    data_out;
`ifdef SWITCH_DROP_CNT_EN
    logic [NP*8-1:0]     drop_cnt;
`endif

    switch_4_port #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .source_in  (source_in),
        .target_in  (target_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .source_out (source_out),
        .target_out (target_out),
        .data_out   (data_out)
`ifdef SWITCH_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] src;
        logic [NP-1:0] tgt;
        logic [DW-1:0] data;
        int            cyc;   // expected edge count, -1 = any
    } exp_t;

    exp_t sb [NP][NP][$];

    int ecount  = 0;
    int n_total = 0;
    int n_pass  = 0;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        for (int k = 0; k < NP; k++) begin
            if (valid_out[k]) begin
                logic [NP-1:0] s;
                logic [NP-1:0] t;
                logic [DW-1:0] d;
                exp_t          e;
                int            si;
                s  = source_out[k*NP +: NP];
                t  = target_out[k*NP +: NP];
                d  = data_out[k*DW +: DW];
                si = 0;
                for (int i = 0; i < NP; i++) if (s[i]) si = i;
                if (!$onehot(s)) begin
                    check(1'b0, $sformatf("src_onehot_e%0d", k), 32'(s), 32'(0));
                end else if (sb[si][k].size() == 0) begin
                    check(1'b0, $sformatf("unexpected_i%0d_e%0d", si, k),
                          32'({s, t, d}), 32'(0));
                end else begin
                    e = sb[si][k].pop_front();
                    check({s, t, d} == {e.src, e.tgt, e.data},
                          $sformatf("pkt_i%0d_e%0d", si, k),
                          32'({s, t, d}), 32'({e.src, e.tgt, e.data}));
                    if (e.cyc >= 0)
                        check(ecount == e.cyc, $sformatf("latency_i%0d_e%0d", si, k),
                              32'(ecount), 32'(e.cyc));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(negedge clk);
        valid_in  = '0;
        source_in = '0;
        target_in = '0;
        data_in   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // lat: edges from this drive to delivery; -1 = any time; -2 = not delivered
    task automatic put(input int p, input logic [NP-1:0] src, input logic [NP-1:0] tgt,
                       input logic [DW-1:0] d, input int lat);
        exp_t e;
        valid_in[p]           = 1'b1;
        source_in[p*NP +: NP] = src;
        target_in[p*NP +: NP] = tgt;
        data_in[p*DW +: DW]   = d;
        if (lat != -2) begin
            for (int k = 0; k < NP; k++) begin
                if (tgt[k]) begin
                    e.src  = src;
                    e.tgt  = tgt;
                    e.data = d;
                    e.cyc  = (lat < 0) ? -1 : ecount + lat;
                    sb[p][k].push_back(e);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check(valid_out == '0,  {tag, "_valid"},  32'(valid_out),  32'(0));
        check(source_out == '0, {tag, "_source"}, 32'(source_out), 32'(0));
        check(target_out == '0, {tag, "_target"}, 32'(target_out), 32'(0));
        check(data_out == '0,   {tag, "_data"},   32'(data_out),   32'(0));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        valid_in  = '0;
        source_in = '0;
        target_in = '0;
        data_in   = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
`ifdef SWITCH_DROP_CNT_EN
        check(drop_cnt == '0, "reset_drop_cnt", drop_cnt, 32'(0));
`endif
        rst_n = 1'b1;
        idle(2);

        // Unicast 0 -> 3
        next_cycle();
        put(0, 4'b0001, 4'b1000, 8'hAB, 2);
        idle(4);

        // Multicast from ingress 1, back to back
        next_cycle();
        put(1, 4'b0010, 4'b0101, 8'h42, 2);
        next_cycle();
        put(1, 4'b0010, 4'b1101, 8'h77, 2);
        idle(4);

        // Broadcast including loopback to egress 2
        next_cycle();
        put(2, 4'b0100, 4'b1111, 8'hFF, 2);
        idle(4);

        // Zero target is discarded
        next_cycle();
        put(3, 4'b1000, 4'b0000, 8'h5A, -2);
        idle(3);

        // Contention on egress 3: ptr[3]=3 so ingress 0 wins, then 1
        next_cycle();
        put(0, 4'b0001, 4'b1000, 8'h11, 2);
        put(1, 4'b0010, 4'b1000, 8'h22, 3);
        idle(4);
        // Unicast from ingress 0 leaves ptr[3]=1
        next_cycle();
        put(0, 4'b0001, 4'b1000, 8'h55, 2);
        idle(4);
        // Second contention round: ingress 1 now wins first
        next_cycle();
        put(0, 4'b0001, 4'b1000, 8'h33, 3);
        put(1, 4'b0010, 4'b1000, 8'h44, 2);
        idle(4);

        // Overflow on ingress 0: eg0 shared three ways, ptr[0]=3 at start.
        // Ingress 0 reaches four entries; arrivals 7 and 8 are dropped
        // (the 8th arrives on a cycle that also pops ingress 0).
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            put(0, 4'b0001, 4'b0001, 8'(8'h01 + i), (i < 6) ? -1 : -2);
            if (i < 4) begin
                put(1, 4'b0010, 4'b0001, 8'(8'h11 + i), -1);
                put(2, 4'b0100, 4'b0001, 8'(8'h21 + i), -1);
            end
        end
        idle(12);
`ifdef SWITCH_DROP_CNT_EN
        check(drop_cnt == 32'h0000_0002, "drop_cnt", drop_cnt, 32'h0000_0002);
`endif

        // Reset mid-traffic: ptr[0]=1, so ingress 1 delivers first, the
        // other three heads are still buffered when reset hits.
        next_cycle();
        put(0, 4'b0001, 4'b0001, 8'hA0, -2);
        put(1, 4'b0010, 4'b0001, 8'hA1, 2);
        put(2, 4'b0100, 4'b0001, 8'hA2, -2);
        put(3, 4'b1000, 4'b0001, 8'hA3, -2);
        next_cycle();
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
`ifdef SWITCH_DROP_CNT_EN
        check(drop_cnt == '0, "midreset_drop_cnt", drop_cnt, 32'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Switch still works after reset
        next_cycle();
        put(3, 4'b1000, 4'b0001, 8'hC3, 2);
        idle(5);

        for (int p = 0; p < NP; p++)
            for (int k = 0; k < NP; k++)
                check(sb[p][k].size() == 0, $sformatf("leftover_i%0d_e%0d", p, k),
                      32'(sb[p][k].size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
